// File: rtl/archel_pkg.sv
// archel_pkg: shared constants and state encoding for the register-file poller.
package archel_pkg;
  localparam int NREGS = 16;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int REGS_W = NREGS * DW;
  localparam int TIMEOUT_DEF = 255;
  localparam int IDLE_GAP_DEF = 1024;
  typedef enum logic [1:0] {IDLE, REQ, RELEASE, GAP} state_e;
endpackage

// File: rtl/handshake_timer.sv
// handshake_timer: loadable down-counter with clear; expired while the count is zero.
module handshake_timer #(
  parameter int CW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [CW-1:0] value_i,
  output logic          expired_o
);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else if (load_i) cnt_q <= value_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
  assign expired_o = cnt_q == '0;
endmodule

// File: rtl/regfile_poller.sv
// regfile_poller: sweeps r0..r15 over a four-phase request/grant handshake
// and publishes only complete sweeps as an atomic snapshot.
module regfile_poller
  import archel_pkg::*;
#(
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int IDLE_GAP = IDLE_GAP_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic              regfile_request_o,
  output logic [AW-1:0]     regfile_ra_o,
  input  logic              regfile_grant_i,
  input  logic [DW-1:0]     regfile_rd_i,
  output logic [REGS_W-1:0] registers_o,
  output logic              snapshot_valid_o,
  output logic [7:0]        sweep_count_o,
  output logic              timeout_err_o,
  output logic              busy_o
);
  localparam int CW = $clog2((TIMEOUT > IDLE_GAP ? TIMEOUT : IDLE_GAP) + 1);
  state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, ra_q;
  logic [NREGS-1:0][DW-1:0] shadow_q;
  logic [REGS_W-1:0] regs_q;
  logic [7:0] sweep_q;
  logic grant_q, req_q, busy_q, snap_q, terr_q;
  logic rise, expired, rel_done, last, commit;
  assign rise = regfile_grant_i & ~grant_q;
  assign rel_done = ~regfile_grant_i | expired;
  assign last = idx_q == AW'(NREGS - 1);
  assign commit = state_q == RELEASE && rel_done && last;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = en_i ? REQ : IDLE;
      REQ:     state_d = (rise | expired) ? RELEASE : REQ;
      RELEASE: state_d = !rel_done ? RELEASE : last ? GAP : en_i ? REQ : IDLE;
      GAP:     state_d = expired ? IDLE : GAP;
    endcase
  end
  assign idx_d = (state_q == RELEASE && rel_done) ? ((last || !en_i) ? '0 : idx_q + AW'(1)) : idx_q;
  // Every transition reloads the shared timer; only the GAP count uses the long period.
  handshake_timer #(.CW(CW)) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q == IDLE && state_d == IDLE),
    .load_i   (state_d != state_q),
    .value_i  (state_d == GAP ? CW'(IDLE_GAP - 1) : CW'(TIMEOUT - 1)),
    .expired_o(expired)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ra_q     <= '0;
      grant_q  <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      snap_q   <= 1'b0;
      terr_q   <= 1'b0;
      sweep_q  <= '0;
      shadow_q <= '0;
      regs_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= regfile_grant_i;
      req_q   <= state_d == REQ;
      busy_q  <= state_d != IDLE;
      ra_q    <= (state_d == REQ || state_d == RELEASE) ? idx_d : '0;
      snap_q  <= commit;
      if (state_q == REQ && rise) shadow_q[idx_q] <= regfile_rd_i;
      // A capture on the expiry edge wins over the timeout.
      if ((state_q == REQ && !rise && expired) || (state_q == RELEASE && regfile_grant_i && expired))
        terr_q <= 1'b1;
      if (commit) begin
        regs_q  <= shadow_q;
        sweep_q <= sweep_q + 8'd1;
      end
    end
  end
  assign regfile_request_o = req_q;
  assign regfile_ra_o      = ra_q;
  assign registers_o       = regs_q;
  assign snapshot_valid_o  = snap_q;
  assign sweep_count_o     = sweep_q;
  assign timeout_err_o     = terr_q;
  assign busy_o            = busy_q;
endmodule

// File: tb/tb_regfile_poller.sv
// tb_regfile_poller: directed checks of sweep, timeout, stale grant, abort, reset and wrap.
module tb_regfile_poller;
  import archel_pkg::*;
  logic clk = 1'b0, rst_ni = 1'b0, en = 1'b0, grant = 1'b0;
  logic [DW-1:0] rd = '0;
  logic req, snap, terr, busy;
  logic [AW-1:0] ra;
  logic [REGS_W-1:0] regs;
  logic [7:0] sweeps;
  int vectors = 0, miscompares = 0, pulses = 0, n;
  bit auto = 1'b1, skip5 = 1'b0;

  regfile_poller #(.TIMEOUT(255), .IDLE_GAP(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en),
    .regfile_request_o(req), .regfile_ra_o(ra),
    .regfile_grant_i(grant), .regfile_rd_i(rd),
    .registers_o(regs), .snapshot_valid_o(snap), .sweep_count_o(sweeps),
    .timeout_err_o(terr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [REGS_W-1:0] got, input logic [REGS_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_pulse(input string tag);
    int k = 0;
    while (!snap && k < 2000) begin @(negedge clk); k++; end
    chk({tag, "_pulse"}, REGS_W'(snap), 1);
  endtask

  task automatic wait_req(input logic [AW-1:0] a, input string tag);
    int k = 0;
    while (!(req && ra == a) && k < 2000) begin @(negedge clk); k++; end
    chk(tag, REGS_W'(req && ra == a), 1);
  endtask

  function automatic logic [REGS_W-1:0] exp_regs(input int hole, input logic [DW-1:0] r0);
    logic [REGS_W-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i*DW +: DW] = (i == hole) ? '0 : DW'(16'h1000 + i);
    v[DW-1:0] = r0;
    return v;
  endfunction

  // Registered responder: grant follows the request seen one cycle earlier.
  initial begin
    logic r;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      r = req;
      a = ra;
      @(posedge clk);
      #1;
      if (auto) begin
        grant = r && !(skip5 && a == 4'd5);
        if (r) rd = DW'(16'h1000) + DW'(a);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (snap) pulses++;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", REGS_W'(req), 0);
    chk("rst_ra", REGS_W'(ra), 0);
    chk("rst_regs", regs, 0);
    chk("rst_flags", REGS_W'({snap, terr, busy, sweeps}), 0);
    rst_ni = 1'b1;
    en = 1'b1;
    // full sweep, then the gap to the next request
    wait_pulse("sweep1");
    chk("sweep1_regs", regs, exp_regs(-1, 16'h1000));
    chk("sweep1_count", REGS_W'(sweeps), 1);
    chk("sweep1_terr", REGS_W'(terr), 0);
    n = 0;
    while (!req && n < 100) begin @(negedge clk); n++; end
    chk("gap_cycles", REGS_W'(n), 17);
    chk("sweep1_pulses", REGS_W'(pulses), 1);
    wait_pulse("sweep2");
    @(negedge clk);
    chk("pulse_width", REGS_W'(snap), 0);
    chk("sweep2_count", REGS_W'(sweeps), 2);
    chk("sweep2_pulses", REGS_W'(pulses), 2);
    // en drop while r7 is requested
    wait_req(4'd7, "abort_r7_req");
    en = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk("abort_cycles", REGS_W'(n), 4);
    chk("abort_ra", REGS_W'(ra), 0);
    chk("abort_regs", regs, exp_regs(-1, 16'h1000));
    chk("abort_pulses", REGS_W'(pulses), 2);
    chk("abort_count", REGS_W'(sweeps), 2);
    // asynchronous reset while requesting r3
    en = 1'b1;
    wait_req(4'd3, "rst_r3_req");
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_req", REGS_W'(req), 0);
    chk("arst_busy", REGS_W'(busy), 0);
    chk("arst_regs", regs, 0);
    chk("arst_count", REGS_W'(sweeps), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    skip5 = 1'b1;
    n = 0;
    while (!req && n < 100) begin @(negedge clk); n++; end
    chk("arst_first_ra", REGS_W'({req, ra}), REGS_W'({1'b1, 4'd0}));
    // r5 is never granted
    wait_req(4'd5, "to_r5_req");
    chk("to_terr_before", REGS_W'(terr), 0);
    n = 0;
    while (req && ra == 4'd5 && n < 400) begin n++; @(negedge clk); end
    chk("to_req_cycles", REGS_W'(n), 255);
    chk("to_terr_after", REGS_W'(terr), 1);
    wait_pulse("to_sweep");
    chk("to_regs", regs, exp_regs(5, 16'h1000));
    chk("to_count", REGS_W'(sweeps), 1);
    en = 1'b0;
    skip5 = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("to_idle", REGS_W'(busy), 0);
    // stale grant: high before the sweep, low at cycle 10, high at cycle 12
    auto = 1'b0;
    @(posedge clk); #1;
    grant = 1'b1;
    rd = 16'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c == 9) chk("stale_hold", REGS_W'({req, ra}), REGS_W'({1'b1, 4'd0}));
      if (c == 10) grant = 1'b0;
      if (c == 12) begin
        chk("stale_no_early", REGS_W'(req), 1);
        grant = 1'b1;
        rd = 16'hABCD;
      end
      if (c == 13) chk("stale_capture", REGS_W'(req), 0);
    end
    auto = 1'b1;
    wait_pulse("stale_sweep");
    chk("stale_regs", regs, exp_regs(-1, 16'hABCD));
    chk("stale_count", REGS_W'(sweeps), 2);
    @(negedge clk);
    // 256 sweeps wrap the counter back to zero
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    for (int s = 0; s < 255; s++) begin
      wait_pulse("wrap");
      @(negedge clk);
    end
    chk("wrap_255", REGS_W'(sweeps), 255);
    wait_pulse("wrap_last");
    @(negedge clk);
    chk("wrap_0", REGS_W'(sweeps), 0);
    chk("wrap_terr", REGS_W'(terr), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_poller.md
Name: regfile_poller

Overview:
- Requester side of the CPU register-file query port (`cpuin_regfile_request` / `ra`, `cpuout_regfile_grant` / `rd`).
- Repeatedly sweeps r0..r15 with a four-phase request/grant handshake and buffers the results in a shadow array.
- Publishes an atomic 256-bit snapshot that feeds the `registers` input of the VRAM text writer.
- Sits in the display path between `cpu` and `write_register`.

Parameters:
- NREGS, 16, registers per sweep; power of two ≤ 16.
- DW, 16, register data width.
- AW, 4, register address width.
- TIMEOUT, 255, max cycles waiting for grant rise or grant fall, per handshake phase.
- IDLE_GAP, 1024, cycles between end of one sweep and start of the next.

Ports:
- clk  in  1  system clock, 100 MHz `CLK`.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  polling enable; level.
- regfile_request  out  1  request to CPU; drives `cpuin_regfile_request`.
- regfile_ra  out  AW  register address; drives `cpuin_regfile_ra`.
- regfile_grant  in  1  grant from CPU; level, edge-detected here.
- regfile_rd  in  DW  register data; valid while grant is high.
- registers  out  NREGS*DW  committed snapshot; r0 in [15:0], rN in [16N+15:16N].
- snapshot_valid  out  1  one-cycle pulse when `registers` updates.
- sweep_count  out  8  completed sweeps, wraps 255→0.
- timeout_err  out  1  sticky; set on any handshake timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): all outputs 0; shadow array 0; FSM=IDLE; idx=0; grant_q=0; counters 0.
- grant_q is grant registered once. rise = grant & ~grant_q.
- IDLE: request=0, ra=0. If en, go REQ with idx=0.
- REQ:
  - request=1, ra=idx, held stable for the whole state.
  - On a clock edge with rise=1: shadow[idx] <= rd sampled that same edge; go RELEASE.
  - Wait counter starts at 0 on entry. If it reaches TIMEOUT with no rise: timeout_err<=1, shadow[idx] unchanged, go RELEASE.
- RELEASE:
  - request=0, ra held.
  - Wait for grant==0, also bounded by TIMEOUT (timeout sets timeout_err and proceeds).
  - Then:
    - idx==NREGS-1: registers<=shadow, snapshot_valid=1 for one cycle, sweep_count+1, idx<=0, go GAP.
    - Else if !en: idx<=0, go IDLE; no commit, no pulse.
    - Else: idx+1, go REQ.
- GAP: request=0. Count IDLE_GAP cycles, then go IDLE. If en is still high, IDLE goes straight to REQ on the next edge.
- Stale grant: a grant already high on entry to REQ produces no rise and is not captured. Capture needs a 0→1 transition.
- Minimum handshake: request cycle N, grant high in N+1 → capture at edge N+1. Grant low in N+3 → next request N+4.
- Simultaneous rise and timeout expiry on the same edge: the capture wins; timeout_err is not set.
- en falling mid-handshake: the current handshake completes; the sweep aborts at the RELEASE boundary.
- registers never shows a partial sweep.

Decomposition:
- Package archel_pkg:
  - constants NREGS, DW, AW, REGS_W=NREGS*DW;
  - poller state enum {IDLE, REQ, RELEASE, GAP};
  - TIMEOUT and IDLE_GAP defaults.
- Sub-module handshake_timer: loadable down-counter with clear and expire flag. Shared by the REQ/RELEASE wait and the GAP count.
- FSM, edge detect and shadow/commit stay in regfile_poller.

Test Plan:
- Responder model grants 1 cycle after request and returns rd=0x1000+ra; en=1 → after one sweep registers={0x100F,…,0x1001,0x1000}, exactly one snapshot_valid pulse, sweep_count=1, timeout_err=0.
- Responder never grants ra=5, TIMEOUT=255 → REQ for r5 lasts 255 cycles, then timeout_err=1. registers[95:80]=0x0000 after commit; all other entries 0x1000+N.
- Grant held high from before sweep start, falls at cycle 10, rises at 12 → r0 captured only at the cycle-12 edge.
- en dropped while r7 is in REQ → r7 handshake completes, FSM goes IDLE with idx=0, registers stays at its prior value, no snapshot_valid.
- rst asserted while in REQ at r3 → request, registers, busy and sweep_count read 0 immediately without a clock edge. After release with en=1, the first request has ra=0.
- Two consecutive sweeps with IDLE_GAP=16 → second request rises 16+1 cycles after the snapshot_valid pulse; sweep_count goes 1→2; the wrap test runs 256 sweeps and ends with sweep_count=0.
